// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit, the instruction memory and decode.
// The fetch unit sits on the master side; the memory/decode environment uses the slave side.
interface fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  modport master (
    input  stall, redirect, redirect_target, imem_instr,
    output imem_addr, id_valid, id_pc, id_pc_plus4, id_instr, fetch_fault, fault_pc
  );

  modport slave (
    output stall, redirect, redirect_target, imem_instr,
    input  imem_addr, id_valid, id_pc, id_pc_plus4, id_instr, fetch_fault, fault_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// PC generation plus the IF/ID register. It handles decode stalls, redirects
// (each costs one bubble) and sticky faults on misaligned or out-of-range PCs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 49,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic        pc_ok;
  logic [31:0] pc_plus4;

  // A wrapped pc+4 can never be fetched: the range check rejects it first.
  assign pc_ok    = (pc_q[1:0] == 2'b00) && (pc_q < IMEM_BYTES);
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_pc_q       <= 32'h0;
      id_pc_plus4_q <= 32'h0;
      id_instr_q    <= NOP_INSTR;
      fault_q       <= 1'b0;
      fault_pc_q    <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_instr_q    <= id_instr_d;
      fault_q       <= fault_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (!bus.redirect && !bus.stall && !pc_ok) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        if (bus.redirect) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_instr_d    = id_instr_q;
    fault_d       = fault_q;
    fault_pc_d    = fault_pc_q;
    case (state_q)
      S_FETCH: begin
        if (bus.redirect) begin
          // The target is not checked here; a bad one faults on the next edge.
          pc_d       = bus.redirect_target;
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (!pc_ok) begin
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
          id_valid_d = 1'b0;
          id_instr_d = NOP_INSTR;
        end else begin
          id_valid_d    = 1'b1;
          id_pc_d       = pc_q;
          id_pc_plus4_d = pc_plus4;
          id_instr_d    = bus.imem_instr;
          pc_d          = pc_plus4;
        end
      end
      S_FAULT: begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
        if (bus.redirect) begin
          pc_d    = bus.redirect_target;
          fault_d = 1'b0;
        end
      end
      default: begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
      end
    endcase
  end

  assign bus.imem_addr   = pc_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc_plus4 = id_pc_plus4_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.fetch_fault = fault_q;
  assign bus.fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a behavioural async instruction memory.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(49),
    .NOP_INSTR (NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] w(input int i);
    if (i == 0) return 32'h0400_0413;
    if (i == 1) return 32'h0320_0493;
    return 32'hA500_0000 | 32'(i * 32'h0000_0101);
  endfunction

  always_comb begin
    bus.imem_instr = 32'hDEAD_BEEF;
    if (bus.imem_addr[1:0] == 2'b00 && bus.imem_addr < 32'd196)
      bus.imem_instr = w(int'(bus.imem_addr[31:2]));
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] id_pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        fault;
    logic [31:0] fault_pc;
    string       note;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] t,
                     input logic [31:0] a, input logic v, input logic [31:0] p,
                     input logic [31:0] p4, input logic [31:0] ins, input logic f,
                     input logic [31:0] fp, input string n);
    vec_t x;
    x = '{r, s, rd, t, a, v, p, p4, ins, f, fp, n};
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic apply_and_check(input vec_t x, input int idx);
    rst                 = x.rst;
    bus.stall           = x.stall;
    bus.redirect        = x.redirect;
    bus.redirect_target = x.target;
    @(posedge clk);
    #1;
    chk({x.note, " imem_addr"},   bus.imem_addr, x.addr);
    chk({x.note, " id_valid"},    32'(bus.id_valid), 32'(x.valid));
    chk({x.note, " id_pc"},       bus.id_pc, x.id_pc);
    chk({x.note, " id_pc_plus4"}, bus.id_pc_plus4, x.pc4);
    chk({x.note, " id_instr"},    bus.id_instr, x.instr);
    chk({x.note, " fetch_fault"}, 32'(bus.fetch_fault), 32'(x.fault));
    chk({x.note, " fault_pc"},    bus.fault_pc, x.fault_pc);
    $display("vec %0d %s: addr=%08h valid=%0b id_pc=%08h instr=%08h fault=%0b fault_pc=%08h",
             idx, x.note, bus.imem_addr, bus.id_valid, bus.id_pc, bus.id_instr,
             bus.fetch_fault, bus.fault_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = 32'h0;

    //  rst stall redir target      addr       v  id_pc      pc4        instr  f  fault_pc
    add(1, 0, 0, 32'h0,  32'h00, 0, 32'h00, 32'h00, NOP,   0, 32'h00, "reset");
    add(0, 0, 0, 32'h0,  32'h04, 1, 32'h00, 32'h04, w(0),  0, 32'h00, "run0");
    add(0, 0, 0, 32'h0,  32'h08, 1, 32'h04, 32'h08, w(1),  0, 32'h00, "run1");
    add(0, 0, 0, 32'h0,  32'h0C, 1, 32'h08, 32'h0C, w(2),  0, 32'h00, "run2");
    add(0, 1, 0, 32'h0,  32'h0C, 1, 32'h08, 32'h0C, w(2),  0, 32'h00, "stall0");
    add(0, 1, 0, 32'h0,  32'h0C, 1, 32'h08, 32'h0C, w(2),  0, 32'h00, "stall1");
    add(0, 1, 0, 32'h0,  32'h0C, 1, 32'h08, 32'h0C, w(2),  0, 32'h00, "stall2");
    add(0, 0, 0, 32'h0,  32'h10, 1, 32'h0C, 32'h10, w(3),  0, 32'h00, "release");
    add(0, 0, 0, 32'h0,  32'h14, 1, 32'h10, 32'h14, w(4),  0, 32'h00, "run4");
    add(0, 0, 0, 32'h0,  32'h18, 1, 32'h14, 32'h18, w(5),  0, 32'h00, "run5");
    add(0, 0, 0, 32'h0,  32'h1C, 1, 32'h18, 32'h1C, w(6),  0, 32'h00, "run6");
    add(0, 0, 0, 32'h0,  32'h20, 1, 32'h1C, 32'h20, w(7),  0, 32'h00, "run7");
    add(0, 1, 1, 32'h18, 32'h18, 0, 32'h1C, 32'h20, NOP,   0, 32'h00, "redir+stall");
    add(0, 0, 0, 32'h0,  32'h1C, 1, 32'h18, 32'h1C, w(6),  0, 32'h00, "after_redir");
    add(0, 0, 1, 32'h1A, 32'h1A, 0, 32'h18, 32'h1C, NOP,   0, 32'h00, "redir_misal");
    add(0, 1, 0, 32'h0,  32'h1A, 0, 32'h18, 32'h1C, NOP,   0, 32'h00, "stall_bubble");
    add(0, 0, 0, 32'h0,  32'h1A, 0, 32'h18, 32'h1C, NOP,   1, 32'h1A, "fault_misal");
    add(0, 1, 0, 32'h0,  32'h1A, 0, 32'h18, 32'h1C, NOP,   1, 32'h1A, "fault_stall");
    add(0, 0, 0, 32'h0,  32'h1A, 0, 32'h18, 32'h1C, NOP,   1, 32'h1A, "fault_hold");
    add(0, 0, 1, 32'h08, 32'h08, 0, 32'h18, 32'h1C, NOP,   0, 32'h1A, "fault_exit");
    add(0, 0, 0, 32'h0,  32'h0C, 1, 32'h08, 32'h0C, w(2),  0, 32'h1A, "resume");
    add(0, 1, 0, 32'h0,  32'h0C, 1, 32'h08, 32'h0C, w(2),  0, 32'h1A, "stall_pre_rst");
    add(1, 1, 0, 32'h0,  32'h00, 0, 32'h00, 32'h00, NOP,   0, 32'h00, "rst_mid_stall");
    add(0, 0, 0, 32'h0,  32'h04, 1, 32'h00, 32'h04, w(0),  0, 32'h00, "restart");

    foreach (vecs[i]) apply_and_check(vecs[i], i);

    // Sequential run off the end of memory, then reset out of FAULT.
    begin
      vec_t x;
      x = '{0, 0, 1, 32'hB8, 32'hB8, 0, 32'h00, 32'h04, NOP, 0, 32'h00, "redir_B8"};
      apply_and_check(x, 100);
      for (int k = 0; k < 3; k++) begin
        logic [31:0] p;
        p = 32'hB8 + 32'(4 * k);
        x = '{0, 0, 0, 32'h0, p + 32'd4, 1, p, p + 32'd4, w(46 + k), 0, 32'h00, "tail"};
        apply_and_check(x, 101 + k);
      end
      x = '{0, 0, 0, 32'h0, 32'hC4, 0, 32'hC0, 32'hC4, NOP, 1, 32'hC4, "fault_range"};
      apply_and_check(x, 104);
      x = '{1, 0, 1, 32'h40, 32'h00, 0, 32'h00, 32'h00, NOP, 0, 32'h00, "rst_in_fault"};
      apply_and_check(x, 105);
      x = '{0, 0, 0, 32'h0, 32'h04, 1, 32'h00, 32'h04, w(0), 0, 32'h00, "restart2"};
      apply_and_check(x, 106);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
